// File: rtl/hacd_axi_mem_responder.sv
// AXI4 slave responder backed by a register-array memory; serves as the DDR stand-in
// behind the HACD crossbar. The read and write paths are independent state machines.
module hacd_axi_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned USER_WIDTH     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [USER_WIDTH-1:0] s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic [USER_WIDTH-1:0] s_axi_buser,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned SZ_MAX = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W  = MEM_ADDR_WIDTH - SZ_MAX;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0;
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(SZ_MAX)) ? 3'(SZ_MAX) : s;
  endfunction

  // Per-beat address step; WRAP keeps the upper bits and wraps the low bits inside the container
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] sz,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << sz;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write path registers
  wstate_e               wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [7:0]            wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic                  wdec_q, wdec_d;
  logic                  mem_we_c;
  logic [IDX_W-1:0]      mem_widx_c;

  // Read path registers
  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [7:0]            rbeat_q, rbeat_d;
  logic                  rdec_q, rdec_d;
  logic [ADDR_WIDTH-1:0] raddr_nxt_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic unused_c;
  assign unused_c = ^{s_axi_awuser, s_axi_aruser};

  assign mem_widx_c  = waddr_q[MEM_ADDR_WIDTH-1:SZ_MAX];
  assign raddr_nxt_c = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
  assign rd_addr_c   = (rstate_q == R_IDLE) ? s_axi_araddr : raddr_nxt_c;
  assign rd_word_c   = mem[rd_addr_c[MEM_ADDR_WIDTH-1:SZ_MAX]];

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axi_wstrb[b]) mem[mem_widx_c][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      wdec_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      wdec_q    <= wdec_d;
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    wdec_d    = wdec_q;
    mem_we_c  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = s_axi_awid;
          waddr_d   = s_axi_awaddr;
          wlen_d    = s_axi_awlen;
          wsize_d   = clamp_size(s_axi_awsize);
          wburst_d  = s_axi_awburst;
          wbeat_d   = '0;
          werr_d    = 1'b0;
          wdec_d    = !in_window(s_axi_awaddr);
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we_c = !wdec_q && rst_n;
          // Burst length comes from AWLEN; WLAST only flags a protocol error
          werr_d   = werr_q | (s_axi_wlast != (wbeat_q == wlen_q));
          if (wbeat_q == wlen_q) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = wid_q;
            bresp_d  = wdec_q ? RESP_DECERR : (werr_d ? RESP_SLVERR : RESP_OKAY);
          end else begin
            wbeat_d = wbeat_q + 8'd1;
            waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rdec_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rdec_q    <= rdec_d;
    end
  end

  // Each accepted beat loads the following one on the same edge, so held rready gives no bubbles
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rdec_d    = rdec_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          raddr_d   = s_axi_araddr;
          rlen_d    = s_axi_arlen;
          rsize_d   = clamp_size(s_axi_arsize);
          rburst_d  = s_axi_arburst;
          rbeat_d   = '0;
          rdec_d    = !in_window(s_axi_araddr);
          rdata_d   = rdec_d ? '0 : rd_word_c;
          rresp_d   = rdec_d ? RESP_DECERR : RESP_OKAY;
          rlast_d   = (s_axi_arlen == 8'd0);
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            raddr_d = raddr_nxt_c;
            rdata_d = rdec_q ? '0 : rd_word_c;
            rlast_d = (rbeat_d == rlen_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_buser   = '0;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_ruser   = '0;

endmodule
